// File: rtl/ip_psds_axil_regs.sv
// ip_psds_axil_regs: AXI4-Lite slave with four 32-bit read/write control registers.
// Ports:
//   s00_axi_aclk / s00_axi_aresetn : clock, synchronous active-low reset
//   s00_axi_aw* / w* / b*          : write address, data and response channels
//   s00_axi_ar* / r*               : read address and data channels
//   reg_out                        : {reg3, reg2, reg1, reg0}
//   wr_pulse                       : one-cycle pulse per register, bit k means regk was written
module ip_psds_axil_regs #(
   parameter int unsigned C_S_AXI_DATA_WIDTH = 32,
   parameter int unsigned C_S_AXI_ADDR_WIDTH = 4
) (
   input  logic                              s00_axi_aclk,
   input  logic                              s00_axi_aresetn,
   input  logic [C_S_AXI_ADDR_WIDTH-1:0]     s00_axi_awaddr,
   input  logic [2:0]                        s00_axi_awprot,
   input  logic                              s00_axi_awvalid,
   output logic                              s00_axi_awready,
   input  logic [C_S_AXI_DATA_WIDTH-1:0]     s00_axi_wdata,
   input  logic [C_S_AXI_DATA_WIDTH/8-1:0]   s00_axi_wstrb,
   input  logic                              s00_axi_wvalid,
   output logic                              s00_axi_wready,
   output logic [1:0]                        s00_axi_bresp,
   output logic                              s00_axi_bvalid,
   input  logic                              s00_axi_bready,
   input  logic [C_S_AXI_ADDR_WIDTH-1:0]     s00_axi_araddr,
   input  logic [2:0]                        s00_axi_arprot,
   input  logic                              s00_axi_arvalid,
   output logic                              s00_axi_arready,
   output logic [C_S_AXI_DATA_WIDTH-1:0]     s00_axi_rdata,
   output logic [1:0]                        s00_axi_rresp,
   output logic                              s00_axi_rvalid,
   input  logic                              s00_axi_rready,
   output logic [4*C_S_AXI_DATA_WIDTH-1:0]   reg_out,
   output logic [3:0]                        wr_pulse
);

   localparam int unsigned DW       = C_S_AXI_DATA_WIDTH;
   localparam int unsigned STRB_W   = C_S_AXI_DATA_WIDTH / 8;
   localparam int unsigned NUM_REGS = 4;
   localparam int unsigned SEL_W    = 2;

   typedef enum logic {WR_IDLE, WR_RESP} wr_state_t;
   typedef enum logic {RD_IDLE, RD_RESP} rd_state_t;

   wr_state_t               wr_state_q, wr_state_d;
   rd_state_t               rd_state_q, rd_state_d;
   logic [DW-1:0]           regs_q [NUM_REGS];
   logic [DW-1:0]           regs_d [NUM_REGS];
   logic                    aw_held_q, aw_held_d;
   logic                    w_held_q, w_held_d;
   logic [SEL_W-1:0]        aw_sel_q, aw_sel_d;
   logic [DW-1:0]           w_data_q, w_data_d;
   logic [STRB_W-1:0]       w_strb_q, w_strb_d;
   logic                    awready_d, wready_d, bvalid_d, arready_d, rvalid_d;
   logic [DW-1:0]           rdata_d;
   logic [3:0]              wr_pulse_d;
   logic                    aw_hs, w_hs, ar_hs;

   // Protection bits and the byte offset inside a word carry no meaning here.
   logic unused_ok;
   assign unused_ok = ^{s00_axi_awprot, s00_axi_arprot, s00_axi_awaddr[1:0], s00_axi_araddr[1:0]};

   assign aw_hs = s00_axi_awvalid & s00_axi_awready;
   assign w_hs  = s00_axi_wvalid  & s00_axi_wready;
   assign ar_hs = s00_axi_arvalid & s00_axi_arready;

   assign s00_axi_bresp = 2'b00;
   assign s00_axi_rresp = 2'b00;

   // Register file exported as a flat vector, reg0 in the low word.
   for (genvar gi = 0; gi < NUM_REGS; gi++) begin : g_reg_out
      assign reg_out[gi*DW +: DW] = regs_q[gi];
   end

   // Write channel: collect AW and W in any order, commit once both are present.
   always_comb begin
      wr_state_d = wr_state_q;
      regs_d     = regs_q;
      aw_held_d  = aw_held_q;
      w_held_d   = w_held_q;
      aw_sel_d   = aw_sel_q;
      w_data_d   = w_data_q;
      w_strb_d   = w_strb_q;
      awready_d  = s00_axi_awready;
      wready_d   = s00_axi_wready;
      bvalid_d   = s00_axi_bvalid;
      wr_pulse_d = '0;
      case (wr_state_q)
         WR_IDLE: begin
            if (aw_hs) begin
               aw_held_d = 1'b1;
               aw_sel_d  = s00_axi_awaddr[3:2];
            end
            if (w_hs) begin
               w_held_d = 1'b1;
               w_data_d = s00_axi_wdata;
               w_strb_d = s00_axi_wstrb;
            end
            if (aw_held_d && w_held_d) begin
               for (int unsigned b = 0; b < STRB_W; b++) begin
                  if (w_strb_d[b]) regs_d[aw_sel_d][b*8 +: 8] = w_data_d[b*8 +: 8];
               end
               wr_pulse_d[aw_sel_d] = 1'b1;
               bvalid_d   = 1'b1;
               awready_d  = 1'b0;
               wready_d   = 1'b0;
               aw_held_d  = 1'b0;
               w_held_d   = 1'b0;
               wr_state_d = WR_RESP;
            end else begin
               // A held beat blocks its own channel until the partner arrives.
               awready_d = ~aw_held_d;
               wready_d  = ~w_held_d;
            end
         end
         WR_RESP: begin
            if (s00_axi_bready) begin
               bvalid_d   = 1'b0;
               awready_d  = 1'b1;
               wready_d   = 1'b1;
               wr_state_d = WR_IDLE;
            end
         end
         default: wr_state_d = WR_IDLE;
      endcase
   end

   // Read channel: capture the pre-edge register value on the AR handshake.
   always_comb begin
      rd_state_d = rd_state_q;
      arready_d  = s00_axi_arready;
      rvalid_d   = s00_axi_rvalid;
      rdata_d    = s00_axi_rdata;
      case (rd_state_q)
         RD_IDLE: begin
            arready_d = 1'b1;
            if (ar_hs) begin
               rdata_d    = regs_q[s00_axi_araddr[3:2]];
               rvalid_d   = 1'b1;
               arready_d  = 1'b0;
               rd_state_d = RD_RESP;
            end
         end
         RD_RESP: begin
            if (s00_axi_rready) begin
               rvalid_d   = 1'b0;
               arready_d  = 1'b1;
               rd_state_d = RD_IDLE;
            end
         end
         default: rd_state_d = RD_IDLE;
      endcase
   end

   // State and output registers.
   always_ff @(posedge s00_axi_aclk) begin
      if (!s00_axi_aresetn) begin
         wr_state_q      <= WR_IDLE;
         rd_state_q      <= RD_IDLE;
         for (int unsigned i = 0; i < NUM_REGS; i++) regs_q[i] <= '0;
         aw_held_q       <= 1'b0;
         w_held_q        <= 1'b0;
         aw_sel_q        <= '0;
         w_data_q        <= '0;
         w_strb_q        <= '0;
         s00_axi_awready <= 1'b0;
         s00_axi_wready  <= 1'b0;
         s00_axi_bvalid  <= 1'b0;
         s00_axi_arready <= 1'b0;
         s00_axi_rvalid  <= 1'b0;
         s00_axi_rdata   <= '0;
         wr_pulse        <= '0;
      end else begin
         wr_state_q      <= wr_state_d;
         rd_state_q      <= rd_state_d;
         regs_q          <= regs_d;
         aw_held_q       <= aw_held_d;
         w_held_q        <= w_held_d;
         aw_sel_q        <= aw_sel_d;
         w_data_q        <= w_data_d;
         w_strb_q        <= w_strb_d;
         s00_axi_awready <= awready_d;
         s00_axi_wready  <= wready_d;
         s00_axi_bvalid  <= bvalid_d;
         s00_axi_arready <= arready_d;
         s00_axi_rvalid  <= rvalid_d;
         s00_axi_rdata   <= rdata_d;
         wr_pulse        <= wr_pulse_d;
      end
   end

endmodule
